// File: rtl/cfu_pkg.sv
// Shared definitions for the N-queens CFU command sequencer: function ids,
// sequencer state encoding and the command record passed to the hold stage.
package cfu_pkg;

  localparam int N_DEFAULT = 16;

  localparam logic [9:0] FID_INIT    = 10'd0;
  localparam logic [9:0] FID_KERNEL  = 10'd1;
  localparam logic [9:0] FID_GET_RET = 10'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_KERN,
    ST_GETRET,
    ST_DONE
  } seq_state_e;

  typedef struct packed {
    logic        valid;
    logic [9:0]  fid;
    logic [31:0] in0;
  } cmd_t;

endpackage

// File: rtl/cfu_cmd_hold.sv
// Command holding register: keeps valid, function id and payload frozen while
// the CFU applies backpressure, and loads the next command otherwise.
module cfu_cmd_hold
  import cfu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  cmd_t nxt_cmd,
  input  logic cmd_ready,
  output cmd_t cmd
);

  cmd_t cmd_q, cmd_d;

  always_comb begin
    cmd_d = cmd_q;
    if (!cmd_q.valid || cmd_ready) cmd_d = nxt_cmd;
  end

  always_ff @(posedge clk) begin
    if (reset) cmd_q <= '0;
    else       cmd_q <= cmd_d;
  end

  assign cmd = cmd_q;

endmodule

// File: rtl/cfu_nq_sequencer.sv
// Autonomous N-queens CFU command sequencer: sweeps first-row columns and sums
// the per-column solution counts. Define CFU_SEQ_WATCHDOG_EN for the kernel-call watchdog.
module cfu_nq_sequencer
  import cfu_pkg::*;
#(
  parameter int          N          = N_DEFAULT,
  parameter int          COL_W      = 5,
  parameter logic [31:0] WDOG_LIMIT = 32'hFFFF_FFFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [COL_W-1:0] col_lo,
  input  logic [COL_W-1:0] col_hi,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      result,
  output logic [31:0]      kcalls,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [9:0]       cmd_payload_function_id,
  output logic [31:0]      cmd_payload_inputs_0,
  output logic [31:0]      cmd_payload_inputs_1,
  output logic [31:0]      cmd_payload_inputs_2,
  input  logic             rsp_valid,
  output logic             rsp_ready,
  input  logic [31:0]      rsp_payload_outputs_0
);

  localparam logic [COL_W-1:0] COL_MAX = COL_W'(N - 1);

  seq_state_e       state_q, state_d;
  logic [COL_W-1:0] cur_q, cur_d;
  logic [COL_W-1:0] hi_q, hi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [31:0]      result_q, result_d;
  logic [31:0]      kcalls_q, kcalls_d;

  cmd_t             nxt_cmd, cmd;
  logic             fire;
  logic             rsp_zero;
  logic [COL_W-1:0] hi_clamped;
  logic             unused_rsp_valid;

`ifdef CFU_SEQ_WATCHDOG_EN
  logic             err_q, err_d;
  logic [31:0]      wdog_q, wdog_d;
`else
  logic [31:0]      unused_wdog_limit;
  assign unused_wdog_limit = WDOG_LIMIT;
`endif

  // The CFU answers combinationally, so a response is taken on the fire cycle.
  assign fire             = cmd.valid && cmd_ready;
  assign rsp_zero         = (rsp_payload_outputs_0 == 32'd0);
  assign hi_clamped       = (col_hi > COL_MAX) ? COL_MAX : col_hi;
  assign unused_rsp_valid = rsp_valid;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    hi_d     = hi_q;
    busy_d   = busy_q;
    result_d = result_q;
    kcalls_d = kcalls_q;
`ifdef CFU_SEQ_WATCHDOG_EN
    err_d    = err_q;
    wdog_d   = wdog_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cur_d    = col_lo;
          hi_d     = hi_clamped;
          result_d = 32'd0;
          kcalls_d = 32'd0;
          busy_d   = 1'b1;
`ifdef CFU_SEQ_WATCHDOG_EN
          err_d    = 1'b0;
          wdog_d   = 32'd0;
`endif
          state_d  = (col_lo > hi_clamped) ? ST_DONE : ST_INIT;
        end
      end
      ST_INIT: begin
        if (fire) state_d = ST_KERN;
      end
      ST_KERN: begin
        if (fire) begin
          kcalls_d = kcalls_q + 32'd1;
`ifdef CFU_SEQ_WATCHDOG_EN
          wdog_d   = wdog_q + 32'd1;
          if (rsp_zero) begin
            state_d = ST_GETRET;
          end else if (wdog_q + 32'd1 == WDOG_LIMIT) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
`else
          if (rsp_zero) state_d = ST_GETRET;
`endif
        end
      end
      ST_GETRET: begin
        if (fire) begin
          result_d = result_q + rsp_payload_outputs_0;
          if (cur_q == hi_q) begin
            state_d = ST_DONE;
          end else begin
            cur_d   = cur_q + COL_W'(1);
            state_d = ST_INIT;
`ifdef CFU_SEQ_WATCHDOG_EN
            wdog_d  = 32'd0;
`endif
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    done_d = (state_d == ST_DONE);
  end

  // Next command follows the next state; the hold stage only loads it when
  // the current command has fired or nothing is pending.
  always_comb begin
    nxt_cmd = '0;
    case (state_d)
      ST_INIT: begin
        nxt_cmd.valid = 1'b1;
        nxt_cmd.fid   = FID_INIT;
        nxt_cmd.in0   = 32'(cur_d);
      end
      ST_KERN: begin
        nxt_cmd.valid = 1'b1;
        nxt_cmd.fid   = FID_KERNEL;
      end
      ST_GETRET: begin
        nxt_cmd.valid = 1'b1;
        nxt_cmd.fid   = FID_GET_RET;
      end
      default: nxt_cmd = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cur_q    <= '0;
      hi_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
      kcalls_q <= 32'd0;
`ifdef CFU_SEQ_WATCHDOG_EN
      err_q    <= 1'b0;
      wdog_q   <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      hi_q     <= hi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      kcalls_q <= kcalls_d;
`ifdef CFU_SEQ_WATCHDOG_EN
      err_q    <= err_d;
      wdog_q   <= wdog_d;
`endif
    end
  end

  cfu_cmd_hold u_cmd_hold (
    .clk       (clk),
    .reset     (reset),
    .nxt_cmd   (nxt_cmd),
    .cmd_ready (cmd_ready),
    .cmd       (cmd)
  );

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign result                  = result_q;
  assign kcalls                  = kcalls_q;
`ifdef CFU_SEQ_WATCHDOG_EN
  assign err                     = err_q;
`else
  assign err                     = 1'b0;
`endif
  assign cmd_valid               = cmd.valid;
  assign cmd_payload_function_id = cmd.fid;
  assign cmd_payload_inputs_0    = cmd.in0;
  assign cmd_payload_inputs_1    = 32'd0;
  assign cmd_payload_inputs_2    = 32'd0;
  assign rsp_ready               = cmd.valid;

endmodule
